// File: rtl/fetch_pkg.sv
// Shared opcodes, FSM state type and fixed instruction words for the fetch stage.
package fetch_pkg;

    localparam logic [3:0] OP_NOOP = 4'd0;
    localparam logic [3:0] OP_LOD  = 4'd1;
    localparam logic [3:0] OP_STR  = 4'd2;
    localparam logic [3:0] OP_BRA  = 4'd4;
    localparam logic [3:0] OP_BRR  = 4'd5;
    localparam logic [3:0] OP_BNE  = 4'd6;
    localparam logic [3:0] OP_ALU  = 4'd8;
    localparam logic [3:0] OP_HLT  = 4'd15;

    localparam logic [31:0] HLT_WORD = 32'hF000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/br_resolve.sv
// Combinational branch resolver: decides whether the branch in IR is taken and where it goes.
module br_resolve
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic [31:0]       ir,
    input  logic [ADDR_W-1:0] ir_pc,
    input  logic [3:0]        stat,
    output logic              taken,
    output logic [ADDR_W-1:0] target
);

    logic [3:0] opcode;
    logic [3:0] mm;
    logic       cond;
    logic       unused_ir;

    assign opcode    = ir[31:28];
    assign mm        = ir[27:24];
    assign cond      = |(mm & stat);
    assign unused_ir = ^ir[23:ADDR_W];

    always_comb begin
        taken  = 1'b0;
        target = ir[ADDR_W-1:0];
        case (opcode)
            OP_BRA: taken = (mm == 4'd0) || cond;
            OP_BRR: begin
                taken  = (mm == 4'd0) || cond;
                // Offset spans the full address width, so sign extension is implicit.
                target = ir_pc + ir[ADDR_W-1:0];
            end
            OP_BNE:  taken = !cond;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC/IR, IMEM request/ack handshake and branch redirect.
// Optional fetch watchdog compiled in with `define FETCH_WDOG_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned           ADDR_W     = 16,
    parameter logic [ADDR_W-1:0]     RESET_PC   = '0,
    parameter int unsigned           WDOG_LIMIT = 16
) (
    input  logic              CLK,
    input  logic              RST_F,
    input  logic              FETCH_EN,
    input  logic              BR_EN,
    input  logic [3:0]        STAT,
    output logic              IMEM_REQ,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    input  logic              IMEM_ACK,
    input  logic [31:0]       IMEM_RDATA,
    output logic [31:0]       IR,
    output logic [3:0]        OPCODE,
    output logic [3:0]        MM,
    output logic [ADDR_W-1:0] PC,
    output logic              IR_VALID,
    output logic              BUSY,
    output logic              FETCH_ERR
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] ir_pc_q;
    logic [31:0]       ir_q;
    logic              req_q;
    logic              ir_valid_q;

    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] pc_next;

    br_resolve #(
        .ADDR_W (ADDR_W)
    ) u_br_resolve (
        .ir     (ir_q),
        .ir_pc  (ir_pc_q),
        .stat   (STAT),
        .taken  (br_taken),
        .target (br_target)
    );

    // Resolved PC in IDLE/HOLD; also the address a same-cycle fetch is issued to.
    assign pc_next = (BR_EN && (state_q == HOLD) && br_taken) ? br_target : pc_q;

`ifdef FETCH_WDOG_EN
    localparam int unsigned WdogW = $clog2(WDOG_LIMIT + 1);
    logic [WdogW-1:0] wdog_q;
    logic             fetch_err_q;
    assign FETCH_ERR = fetch_err_q;
`else
    logic unused_wdog;
    assign unused_wdog = (WDOG_LIMIT == 0);
    assign FETCH_ERR   = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            ir_pc_q    <= RESET_PC;
            ir_q       <= 32'd0;
            req_q      <= 1'b0;
            ir_valid_q <= 1'b0;
`ifdef FETCH_WDOG_EN
            wdog_q      <= '0;
            fetch_err_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, HOLD: begin
                    pc_q <= pc_next;
                    if (FETCH_EN) begin
                        state_q    <= REQ;
                        addr_q     <= pc_next;
                        req_q      <= 1'b1;
                        ir_valid_q <= 1'b0;
`ifdef FETCH_WDOG_EN
                        wdog_q     <= '0;
`endif
                    end
                end
                REQ: begin
                    if (IMEM_ACK) begin
                        state_q    <= HOLD;
                        ir_q       <= IMEM_RDATA;
                        ir_pc_q    <= addr_q;
                        pc_q       <= addr_q + 1'b1;
                        req_q      <= 1'b0;
                        ir_valid_q <= 1'b1;
                    end
`ifdef FETCH_WDOG_EN
                    else if (wdog_q == WdogW'(WDOG_LIMIT - 1)) begin
                        // Give up: present a halt so the controller stops cleanly.
                        state_q     <= HOLD;
                        ir_q        <= HLT_WORD;
                        req_q       <= 1'b0;
                        ir_valid_q  <= 1'b1;
                        fetch_err_q <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign IMEM_REQ  = req_q;
    assign IMEM_ADDR = addr_q;
    assign BUSY      = req_q;
    assign IR        = ir_q;
    assign OPCODE    = ir_q[31:28];
    assign MM        = ir_q[27:24];
    assign PC        = pc_q;
    assign IR_VALID  = ir_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic vs. a model.
module tb_fetch_unit;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned WDOG_LIMIT = 16;

    logic              CLK = 1'b0;
    logic              RST_F = 1'b0;
    logic              FETCH_EN = 1'b0;
    logic              BR_EN = 1'b0;
    logic [3:0]        STAT = 4'd0;
    logic              IMEM_REQ;
    logic [ADDR_W-1:0] IMEM_ADDR;
    logic              IMEM_ACK = 1'b0;
    logic [31:0]       IMEM_RDATA = 32'd0;
    logic [31:0]       IR;
    logic [3:0]        OPCODE;
    logic [3:0]        MM;
    logic [ADDR_W-1:0] PC;
    logic              IR_VALID;
    logic              BUSY;
    logic              FETCH_ERR;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one instruction slot, one outstanding request.
    logic [15:0] m_pc, m_addr, m_irpc;
    logic [31:0] m_ir;
    logic        m_valid, m_busy, m_err;
    int          m_wait;

    fetch_unit #(
        .ADDR_W     (ADDR_W),
        .RESET_PC   (16'h0000),
        .WDOG_LIMIT (WDOG_LIMIT)
    ) dut (
        .CLK        (CLK),
        .RST_F      (RST_F),
        .FETCH_EN   (FETCH_EN),
        .BR_EN      (BR_EN),
        .STAT       (STAT),
        .IMEM_REQ   (IMEM_REQ),
        .IMEM_ADDR  (IMEM_ADDR),
        .IMEM_ACK   (IMEM_ACK),
        .IMEM_RDATA (IMEM_RDATA),
        .IR         (IR),
        .OPCODE     (OPCODE),
        .MM         (MM),
        .PC         (PC),
        .IR_VALID   (IR_VALID),
        .BUSY       (BUSY),
        .FETCH_ERR  (FETCH_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0; m_addr = 16'h0; m_irpc = 16'h0; m_ir = 32'h0;
        m_valid = 1'b0; m_busy = 1'b0; m_err = 1'b0; m_wait = 0;
    endtask

    task automatic model_edge(input logic fe, input logic be, input logic [3:0] st,
                              input logic ack, input logic [31:0] rd);
        logic [3:0] op, mm;
        logic       hit;
        int         t;
        if (!m_busy) begin
            op  = m_ir[31:28];
            mm  = m_ir[27:24];
            hit = (mm & st) != 4'd0;
            if (be && m_valid) begin
                if (op == 4'd4 && (mm == 4'd0 || hit)) m_pc = m_ir[15:0];
                if (op == 4'd6 && !hit) m_pc = m_ir[15:0];
                if (op == 4'd5 && (mm == 4'd0 || hit)) begin
                    t    = int'(m_irpc) + int'($signed(m_ir[15:0]));
                    m_pc = t[15:0];
                end
            end
            if (fe) begin
                m_busy = 1'b1; m_addr = m_pc; m_valid = 1'b0; m_wait = 0;
            end
        end else if (ack) begin
            m_ir = rd; m_irpc = m_addr; m_pc = m_addr + 16'd1;
            m_valid = 1'b1; m_busy = 1'b0;
        end else begin
`ifdef FETCH_WDOG_EN
            m_wait++;
            if (m_wait == WDOG_LIMIT) begin
                m_ir = 32'hF000_0000; m_valid = 1'b1; m_busy = 1'b0; m_err = 1'b1;
            end
`endif
        end
    endtask

    task automatic check_all();
        check_eq("pc", 32'(PC), 32'(m_pc));
        check_eq("ir", IR, m_ir);
        check_eq("opcode", 32'(OPCODE), 32'(m_ir[31:28]));
        check_eq("mm", 32'(MM), 32'(m_ir[27:24]));
        check_eq("ir_valid", 32'(IR_VALID), 32'(m_valid));
        check_eq("imem_req", 32'(IMEM_REQ), 32'(m_busy));
        check_eq("busy", 32'(BUSY), 32'(m_busy));
        check_eq("imem_addr", 32'(IMEM_ADDR), 32'(m_addr));
        check_eq("fetch_err", 32'(FETCH_ERR), 32'(m_err));
    endtask

    // One clock: drive inputs, let the edge happen, update model, compare 1 ns later.
    task automatic cyc(input logic fe, input logic be, input logic [3:0] st,
                       input logic ack, input logic [31:0] rd);
        FETCH_EN = fe; BR_EN = be; STAT = st; IMEM_ACK = ack; IMEM_RDATA = rd;
        @(posedge CLK);
        model_edge(fe, be, st, ack, rd);
        #1;
        check_all();
    endtask

    logic [3:0] ops [7] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd8, 4'd15};

    initial begin
        model_reset();
        #12;
        check_all();
        @(negedge CLK);
        RST_F = 1'b1;

        // Zero-wait fetch from address 0.
        cyc(1'b1, 1'b0, 4'd0, 1'b0, 32'h0);
        check_eq("first_addr", 32'(IMEM_ADDR), 32'h0);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 32'h8000_0000);
        check_eq("first_ir", IR, 32'h8000_0000);
        check_eq("first_op", 32'(OPCODE), 32'd8);
        check_eq("first_pc", 32'(PC), 32'd1);
        check_eq("first_valid", 32'(IR_VALID), 32'd1);

        // Slow memory: five idle cycles, stray FETCH_EN in the middle.
        cyc(1'b1, 1'b0, 4'd0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            cyc(i == 2, 1'b0, 4'd0, 1'b0, 32'hDEAD_BEEF);
            check_eq("wait_addr", 32'(IMEM_ADDR), 32'd1);
            check_eq("wait_req", 32'(IMEM_REQ), 32'd1);
        end
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 32'h4100_0020);

        // bra with MM=1: taken on STAT bit 0, not taken on STAT=0.
        cyc(1'b0, 1'b1, 4'b0001, 1'b0, 32'h0);
        check_eq("bra_taken", 32'(PC), 32'h20);
        cyc(1'b0, 1'b1, 4'b0000, 1'b0, 32'h0);
        check_eq("bra_not_taken", 32'(PC), 32'h20);

        // Jump to 0x10, then brr -2 from there.
        cyc(1'b1, 1'b0, 4'd0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 32'h4000_0010);
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 4'd0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 32'h5000_FFFE);
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 32'h0);
        check_eq("brr_back", 32'(PC), 32'h0E);

        // Branch + fetch together to 0xFFFF, then PC wraps.
        cyc(1'b1, 1'b0, 4'd0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 32'h4000_FFFF);
        cyc(1'b1, 1'b1, 4'd0, 1'b0, 32'h0);
        check_eq("br_fetch_addr", 32'(IMEM_ADDR), 32'hFFFF);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 32'h8000_0000);
        check_eq("pc_wrap", 32'(PC), 32'h0);

        // Reset during an outstanding request, then a late ACK.
        cyc(1'b1, 1'b0, 4'd0, 1'b0, 32'h0);
        #3 RST_F = 1'b0;
        #1;
        model_reset();
        check_eq("rst_req_async", 32'(IMEM_REQ), 32'd0);
        @(negedge CLK);
        RST_F = 1'b1;
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 32'h1234_5678);
        check_eq("late_ack_ir", IR, 32'h0);
        check_eq("late_ack_valid", 32'(IR_VALID), 32'd0);

`ifdef FETCH_WDOG_EN
        cyc(1'b1, 1'b0, 4'd0, 1'b0, 32'h0);
        for (int i = 0; i < WDOG_LIMIT; i++) cyc(1'b0, 1'b0, 4'd0, 1'b0, 32'h0);
        check_eq("wdog_op", 32'(OPCODE), 32'd15);
        check_eq("wdog_err", 32'(FETCH_ERR), 32'd1);
        check_eq("wdog_req", 32'(IMEM_REQ), 32'd0);
`else
        cyc(1'b1, 1'b0, 4'd0, 1'b0, 32'h0);
        for (int i = 0; i < 3 * WDOG_LIMIT; i++) cyc(1'b0, 1'b0, 4'd0, 1'b0, 32'h0);
        check_eq("long_wait_busy", 32'(BUSY), 32'd1);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 32'h8000_0001);
`endif

        // Randomized traffic, including stray ACK/FETCH_EN/BR_EN while busy.
        for (int i = 0; i < 3000; i++) begin
            logic        fe, be, ack;
            logic [31:0] rd;
            fe  = ($urandom_range(0, 3) == 0);
            be  = ($urandom_range(0, 2) == 0);
            ack = ($urandom_range(0, 2) == 0);
            rd  = {ops[$urandom_range(0, 6)], 4'($urandom), 24'($urandom)};
            cyc(fe, be, 4'($urandom), ack, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage feeding the control FSM. Holds the program counter and instruction register, and runs a request/acknowledge handshake with instruction memory. Exposes the opcode and addressing-mode fields the controller decodes, and applies branch redirects (bra, brr, bne) when the controller asks for them.

## Interface
- ADDR_W, 16, PC and instruction-memory address width (word-addressed).
- RESET_PC, 0, PC value loaded on reset.
- WDOG_LIMIT, 16, cycles to wait for IMEM_ACK before a fetch error (used only with watchdog compiled in).

Ports (reset RST_F is asynchronous, active-low; clock is CLK):
- CLK  in  1  clock; all state updates on the rising edge.
- RST_F  in  1  asynchronous active-low reset.
- FETCH_EN  in  1  single-cycle pulse from the controller requesting the next instruction.
- BR_EN  in  1  single-cycle pulse from the controller: resolve the branch held in IR.
- STAT  in  4  ALU status flags used for branch conditions.
- IMEM_REQ  out  1  memory request.
- IMEM_ADDR  out  ADDR_W  request address.
- IMEM_ACK  in  1  memory acknowledge; IMEM_RDATA is valid in the same cycle.
- IMEM_RDATA  in  32  instruction word.
- IR  out  32  current instruction.
- OPCODE  out  4  IR[31:28].
- MM  out  4  IR[27:24].
- PC  out  ADDR_W  address of the next instruction to fetch.
- IR_VALID  out  1  IR holds a completed fetch.
- BUSY  out  1  a request is outstanding.
- FETCH_ERR  out  1  sticky watchdog error flag.

## Operation
- States:
  - IDLE: no valid IR.
  - REQ: request outstanding.
  - HOLD: IR valid.
- Transitions:
  - IDLE/HOLD + FETCH_EN → REQ.
  - REQ + IMEM_ACK → HOLD.
  - REQ + watchdog expiry → HOLD.
- On entry to REQ:
  - Capture the request address into an address register.
  - Hold IMEM_REQ=1 and IMEM_ADDR stable until ACK is sampled.
- On ACK:
  - IR ← IMEM_RDATA.
  - IR_PC ← request address.
  - PC ← request address + 1, modulo 2^ADDR_W (wraps to 0).
  - IR_VALID ← 1.
- FETCH_EN or BR_EN while in REQ: ignored. The controller must not issue them there.
- Branch resolution (only when BR_EN is set and the state is HOLD). Condition: `c = (MM & STAT) != 0`.
  - bra (4): taken if MM==0 or c; PC ← IR[ADDR_W-1:0].
  - brr (5): taken if MM==0 or c; PC ← IR_PC + sign-extended IR[ADDR_W-1:0], modulo 2^ADDR_W.
  - bne (6): taken if `(MM & STAT) == 0`; PC ← IR[ADDR_W-1:0].
  - Not taken, or any other opcode: PC unchanged.
- FETCH_EN and BR_EN in the same cycle: the fetch is issued to the resolved branch target (or to PC if not taken).
- IMEM_ACK outside REQ is ignored.

## Timing
- Reset values:
  - PC=RESET_PC.
  - IR=0 (noop), so OPCODE=0 and MM=0.
  - IR_VALID=0, IMEM_REQ=0, IMEM_ADDR=RESET_PC, BUSY=0, FETCH_ERR=0.
  - State=IDLE.
- Fetch latency:
  - FETCH_EN sampled at edge t → IMEM_REQ=1 and BUSY=1 after edge t.
  - ACK sampled at edge t+k → IR, PC and IR_VALID update at edge t+k; IMEM_REQ and BUSY drop at edge t+k.
  - With a zero-wait memory (ACK at t+1), IR is valid 2 edges after FETCH_EN.
- IR_VALID drops in the cycle REQ is entered and rises on ACK.
- Branch: PC updates on the edge BR_EN is sampled.
- Reset mid-request:
  - IMEM_REQ drops asynchronously.
  - A late ACK after reset release is ignored.

## Configuration
- Macro `FETCH_WDOG_EN`.
- Defined:
  - A counter runs while in REQ and clears on ACK.
  - When it reaches WDOG_LIMIT with no ACK: IR ← 32'hF000_0000 (hlt), IR_VALID=1, FETCH_ERR=1 (sticky until reset), IMEM_REQ drops, PC is unchanged.
- Undefined:
  - No counter; REQ waits indefinitely.
  - FETCH_ERR is tied to 0.

## Structure
- Package fetch_pkg holds:
  - Opcode constants: noop=0, lod=1, str=2, bra=4, brr=5, bne=6, alu=8, hlt=15.
  - The state enum (IDLE, REQ, HOLD).
  - The hlt instruction word constant.
- Sub-module br_resolve: combinational. Inputs are IR, IR_PC and STAT; outputs are taken and target.

## Test plan
- Reset then FETCH_EN with zero-wait memory returning 32'h8000_0000 at address 0 → IMEM_ADDR=0; IR=32'h8000_0000, OPCODE=8, PC=1, IR_VALID=1 two edges after FETCH_EN.
- ACK delayed 5 cycles → IMEM_REQ high and IMEM_ADDR constant for all 5 cycles; BUSY=1 throughout; FETCH_EN pulsed mid-wait has no effect.
- IR=32'h4100_0020 (bra, MM=1), STAT=4'b0001, BR_EN → PC=0x20. Repeat with STAT=0 → PC unchanged.
- brr with IR_PC=0x10 and offset 0xFFFE, MM=0 → PC=0x0E. PC=0xFFFF and fetch completes → PC wraps to 0.
- RST_F low during REQ, then a late ACK → state IDLE, IR=0, IR_VALID=0, PC=RESET_PC; the ACK is ignored.
- With FETCH_WDOG_EN and no ACK for 16 cycles → OPCODE=15, FETCH_ERR=1, IMEM_REQ=0.
